reg_file_sb: RTL and testbench

//  Parametrised register file for the single- and multi-cycle RISC-V cores, with N combinational read ports.

---
 rtl/reg_file_sb_if.sv | 35 +++
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file bus: write/extension, read ports, and scoreboard issue/flush.
// Decode/writeback side uses master; the register file uses slave.
interface reg_file_sb_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    parameter int unsigned NREAD = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic                    we;
    logic [AW-1:0]           Rd;
    logic [XLEN-1:0]         data_in;
    logic [1:0]              wsize;
    logic                    sign_extend;
    logic                    zero_extend;
    logic [NREAD*AW-1:0]     Rs;
    logic [NREAD*XLEN-1:0]   read_data;
    logic [NREAD-1:0]        rs_ready;
    logic                    issue_valid;
    logic [AW-1:0]           issue_rd;
    logic                    flush;
    logic                    any_busy;

    modport master (
        output we, Rd, data_in, wsize, sign_extend, zero_extend, Rs,
        output issue_valid, issue_rd, flush,
        input  read_data, rs_ready, any_busy
    );

    modport slave (
        input  we, Rd, data_in, wsize, sign_extend, zero_extend, Rs,
        input  issue_valid, issue_rd, flush,
        output read_data, rs_ready, any_busy
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with write-data extension, optional write-to-read bypass and a
// per-register busy scoreboard used by the multi-cycle core to stall on pending writebacks.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREGS);
    localparam bit          ZR = (ZERO_REG != 0);
    localparam bit          BP = (BYPASS != 0);

    logic [XLEN-1:0]       r_regs [NREGS];
    logic [NREGS-1:0]      r_busy;
    logic [NREGS-1:0]      w_busy_nxt;
    logic [XLEN-1:0]       w_wext;
    logic                  w_wr_ok;
    logic [AW-1:0]         w_rs [NREAD];
    logic [NREAD-1:0]      w_hit;
    logic [NREAD*XLEN-1:0] w_read_data;
    logic [NREAD-1:0]      w_rs_ready;

    // Byte/half extension; sign_extend takes priority, word size passes through.
    always_comb begin
        w_wext = bus.data_in;
        if (bus.wsize == 2'b00) begin
            if (bus.sign_extend)
                w_wext = {{(XLEN-8){bus.data_in[7]}}, bus.data_in[7:0]};
            else if (bus.zero_extend)
                w_wext = {{(XLEN-8){1'b0}}, bus.data_in[7:0]};
        end else if (bus.wsize == 2'b01) begin
            if (bus.sign_extend)
                w_wext = {{(XLEN-16){bus.data_in[15]}}, bus.data_in[15:0]};
            else if (bus.zero_extend)
                w_wext = {{(XLEN-16){1'b0}}, bus.data_in[15:0]};
        end
    end

    assign w_wr_ok = bus.we && !(ZR && (bus.Rd == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[bus.Rd] <= w_wext;
        end
    end

    // Scoreboard: flush beats issue, issue beats the writeback clear on the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (bus.flush) begin
            w_busy_nxt = '0;
        end else begin
            if (bus.we)          w_busy_nxt[bus.Rd]       = 1'b0;
            if (bus.issue_valid) w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        if (ZR) w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    for (genvar g = 0; g < int'(NREAD); g++) begin : g_rs
        assign w_rs[g]  = bus.Rs[g*AW +: AW];
        assign w_hit[g] = BP && bus.we && (bus.Rd == w_rs[g]);
    end

    // Combinational read ports; a hit also makes a pending register ready this cycle.
    always_comb begin
        w_read_data = '0;
        w_rs_ready  = '0;
        for (int i = 0; i < int'(NREAD); i++) begin
            if (ZR && (w_rs[i] == '0))
                w_read_data[i*XLEN +: XLEN] = '0;
            else if (w_hit[i])
                w_read_data[i*XLEN +: XLEN] = w_wext;
            else
                w_read_data[i*XLEN +: XLEN] = r_regs[w_rs[i]];
            w_rs_ready[i] = !r_busy[w_rs[i]] || w_hit[i];
        end
    end

    assign bus.read_data = w_read_data;
    assign bus.rs_ready  = w_rs_ready;
    assign bus.any_busy  = |r_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench: two register-file configurations driven in lockstep, checked
// against a behavioural model of the register/busy state.
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) ifa ();
    reg_file_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) ifb ();

    reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1), .BYPASS(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    reg_file_sb #(.XLEN(64), .NREGS(16), .NREAD(3), .ZERO_REG(1), .BYPASS(0))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    typedef struct {
        bit              we;
        int unsigned     rd;
        logic [63:0]     din;
        logic [1:0]      ws;
        bit              se;
        bit              ze;
        int unsigned     rs [3];
        bit              iv;
        int unsigned     ird;
        bit              fl;
    } stim_t;

    typedef struct {
        logic [191:0] rd;
        logic [2:0]   rdy;
        logic         anyb;
        string        tag;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Model configuration: index 0 = dut_a, 1 = dut_b
    int unsigned cfg_xlen  [2] = '{32, 64};
    int unsigned cfg_nregs [2] = '{32, 16};
    int unsigned cfg_nread [2] = '{2, 3};
    bit          cfg_byp   [2] = '{1'b1, 1'b0};

    logic [63:0] mem  [2][32];
    bit          busy [2][32];
    bit          known = 1'b0;

    int tot = 0;
    int bad = 0;

    function automatic logic [63:0] ext(stim_t s, int unsigned xl);
        logic [63:0] mask, f, r;
        if (s.ws[1]) begin
            r = s.din;
        end else begin
            mask = (s.ws == 2'b00) ? 64'hFF : 64'hFFFF;
            f    = s.din & mask;
            if (s.se)      r = ((s.din & (mask ^ (mask >> 1))) != 0) ? (f | ~mask) : f;
            else if (s.ze) r = f;
            else           r = s.din;
        end
        if (xl == 32) r = r & 64'hFFFF_FFFF;
        return r;
    endfunction

    function automatic exp_t predict(int m, stim_t s, string tag);
        exp_t        e;
        logic [63:0] w, v;
        int unsigned a;
        bit          hit;
        e.rd = '0; e.rdy = '0; e.anyb = 1'b0; e.tag = tag;
        w = ext(s, cfg_xlen[m]);
        for (int i = 0; i < int'(cfg_nread[m]); i++) begin
            a   = s.rs[i];
            hit = cfg_byp[m] && s.we && (s.rd == a);
            if (a == 0)   v = 64'h0;
            else if (hit) v = w;
            else          v = mem[m][a];
            e.rd   = e.rd | (192'(v) << (i * int'(cfg_xlen[m])));
            e.rdy[i] = !busy[m][a] || hit;
        end
        for (int j = 0; j < int'(cfg_nregs[m]); j++) e.anyb = e.anyb | busy[m][j];
        return e;
    endfunction

    function automatic void advance(int m, stim_t s, bit r);
        if (r) begin
            for (int j = 0; j < 32; j++) begin mem[m][j] = 64'h0; busy[m][j] = 1'b0; end
            return;
        end
        if (s.we && s.rd != 0) mem[m][s.rd] = ext(s, cfg_xlen[m]);
        if (s.fl) begin
            for (int j = 0; j < 32; j++) busy[m][j] = 1'b0;
        end else begin
            if (s.we) busy[m][s.rd]  = 1'b0;
            if (s.iv) busy[m][s.ird] = 1'b1;
        end
        busy[m][0] = 1'b0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.we = 0; s.rd = 0; s.din = '0; s.ws = 2'b10; s.se = 0; s.ze = 0;
        s.rs = '{0, 0, 0}; s.iv = 0; s.ird = 0; s.fl = 0;
        return s;
    endfunction

    function automatic stim_t rnd(int unsigned nregs);
        stim_t s;
        s.we  = ($urandom_range(0, 1) == 1);
        s.rd  = $urandom_range(0, nregs - 1);
        s.din = {$urandom, $urandom};
        s.ws  = 2'($urandom_range(0, 3));
        s.se  = ($urandom_range(0, 1) == 1);
        s.ze  = ($urandom_range(0, 1) == 1);
        for (int i = 0; i < 3; i++) s.rs[i] = $urandom_range(0, nregs - 1);
        s.iv  = ($urandom_range(0, 9) < 3);
        s.ird = $urandom_range(0, nregs - 1);
        s.fl  = ($urandom_range(0, 19) == 0);
        return s;
    endfunction

    task automatic cycle(stim_t sa, stim_t sb, bit r, string tag);
        rst = r;
        ifa.we = sa.we; ifa.Rd = 5'(sa.rd); ifa.data_in = 32'(sa.din); ifa.wsize = sa.ws;
        ifa.sign_extend = sa.se; ifa.zero_extend = sa.ze;
        ifa.Rs = {5'(sa.rs[1]), 5'(sa.rs[0])};
        ifa.issue_valid = sa.iv; ifa.issue_rd = 5'(sa.ird); ifa.flush = sa.fl;
        ifb.we = sb.we; ifb.Rd = 4'(sb.rd); ifb.data_in = sb.din; ifb.wsize = sb.ws;
        ifb.sign_extend = sb.se; ifb.zero_extend = sb.ze;
        ifb.Rs = {4'(sb.rs[2]), 4'(sb.rs[1]), 4'(sb.rs[0])};
        ifb.issue_valid = sb.iv; ifb.issue_rd = 4'(sb.ird); ifb.flush = sb.fl;
        if (known) begin
            qa.push_back(predict(0, sa, tag));
            qb.push_back(predict(1, sb, tag));
        end
        advance(0, sa, r);
        advance(1, sb, r);
        @(posedge clk);
        #1;
        if (r) known = 1'b1;
    endtask

    task automatic chk(string name, string tag, logic [191:0] got, logic [191:0] exp);
        tot++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s.%s got=%h exp=%h", tag, name, got, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each driven cycle presents one response at negedge.
    always @(negedge clk) begin
        exp_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("a_rdata", e.tag, 192'(ifa.read_data), e.rd);
            chk("a_ready", e.tag, 192'(ifa.rs_ready), 192'(e.rdy[1:0]));
            chk("a_busy",  e.tag, 192'(ifa.any_busy), 192'(e.anyb));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("b_rdata", e.tag, 192'(ifb.read_data), e.rd);
            chk("b_ready", e.tag, 192'(ifb.rs_ready), 192'(e.rdy));
            chk("b_busy",  e.tag, 192'(ifb.any_busy), 192'(e.anyb));
        end
    end

    initial begin
        stim_t sa, sb, z;
        z = idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle(z, z, 1'b1, "rst0");
        cycle(z, z, 1'b1, "rst1");

        // Basic write then read
        sa = z; sa.rs = '{0, 5, 0};                    cycle(sa, z, 0, "t1_rd0");
        sa = z; sa.we = 1; sa.rd = 5; sa.din = 64'h1234_5678; cycle(sa, z, 0, "t1_wr");
        sa = z; sa.rs = '{5, 5, 0};                    cycle(sa, z, 0, "t1_rd");

        // Extension cases
        sa = z; sa.we = 1; sa.rd = 3; sa.din = 64'h80; sa.ws = 0; sa.se = 1; sa.rs = '{3, 0, 0};
        cycle(sa, z, 0, "t2_sb");
        sa = z; sa.rs = '{3, 3, 0};                    cycle(sa, z, 0, "t2_sb_rd");
        sa = z; sa.we = 1; sa.rd = 3; sa.din = 64'h80; sa.ws = 0; sa.ze = 1; cycle(sa, z, 0, "t2_zb");
        sa = z; sa.rs = '{3, 3, 0};                    cycle(sa, z, 0, "t2_zb_rd");
        sa = z; sa.we = 1; sa.rd = 3; sa.din = 64'h1_8000; sa.ws = 1; sa.se = 1; sa.ze = 1;
        cycle(sa, z, 0, "t2_sh");
        sa = z; sa.rs = '{3, 3, 0};                    cycle(sa, z, 0, "t2_sh_rd");

        // Register zero
        sa = z; sa.we = 1; sa.rd = 0; sa.din = 64'hDEAD_BEEF; sa.iv = 1; sa.ird = 0;
        cycle(sa, z, 0, "t3_x0");
        sa = z; sa.rs = '{0, 0, 0};                    cycle(sa, z, 0, "t3_rd");

        // Issue, then bypassed writeback clears pending
        sa = z; sa.iv = 1; sa.ird = 7;                 cycle(sa, z, 0, "t4_iss");
        sa = z; sa.rs = '{7, 7, 0};                    cycle(sa, z, 0, "t4_pend");
        sa = z; sa.we = 1; sa.rd = 7; sa.din = 64'h55; sa.rs = '{0, 7, 0}; cycle(sa, z, 0, "t4_byp");
        sa = z; sa.rs = '{7, 7, 0};                    cycle(sa, z, 0, "t4_clr");

        // Issue+write same register, then flush with issue
        sa = z; sa.we = 1; sa.rd = 9; sa.din = 64'hA5A5_0009; sa.iv = 1; sa.ird = 9;
        cycle(sa, z, 0, "t5_iw");
        sa = z; sa.rs = '{9, 9, 0};                    cycle(sa, z, 0, "t5_rd");
        sa = z; sa.fl = 1; sa.iv = 1; sa.ird = 10; sa.rs = '{10, 9, 0}; cycle(sa, z, 0, "t5_fl");
        sa = z; sa.rs = '{10, 9, 0};                   cycle(sa, z, 0, "t5_after");

        // No-bypass configuration: 64-bit, 16 regs, 3 ports
        sb = z; sb.we = 1; sb.rd = 15; sb.din = 64'hCAFE_F00D_1234_5678; sb.rs = '{15, 15, 15};
        cycle(z, sb, 0, "t6_wr");
        sb = z; sb.rs = '{15, 15, 15};                 cycle(z, sb, 0, "t6_rd");
        sb = z; sb.iv = 1; sb.ird = 4;                 cycle(z, sb, 0, "t6_iss");
        sb = z; sb.we = 1; sb.rd = 4; sb.din = 64'hFF; sb.ws = 0; sb.se = 1; sb.rs = '{4, 0, 15};
        cycle(z, sb, 0, "t6_wb");
        sb = z; sb.rs = '{4, 4, 0};                    cycle(z, sb, 0, "t6_rdy");

        // Randomised traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            cycle(rnd(32), rnd(16), ($urandom_range(0, 60) == 0), "rand");
        end

        cycle(z, z, 0, "tail");
        #10;
        if (qa.size() != 0 || qb.size() != 0) begin
            tot++; bad++;
            $display("FAIL drain pending_a=%0d pending_b=%0d required=0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule
